// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-beat request/response initiator for an asynchronous memory with programmable wait cycles
// Optional per-type transaction counters are enabled by defining MEM_BUS_STATS_EN.
module mem_bus_master #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
`ifdef MEM_BUS_STATS_EN
    ,
    output logic [31:0]           stat_rd_count,
    output logic [31:0]           stat_wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter starts at WAIT_CYCLES-1 so the lines stay enabled for exactly WAIT_CYCLES clocks.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_we_q, rsp_we_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  mem_enable_q, mem_enable_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_we_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_enable_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_we_q      <= rsp_we_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_enable_q  <= mem_enable_d;
            mem_we_q      <= mem_we_d;
            mem_address_q <= mem_address_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    // Next-state logic: accept in IDLE, hold lines during ACCESS, hold response in RESP.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_we_d      = rsp_we_q;
        rsp_rdata_d   = rsp_rdata_q;
        mem_enable_d  = mem_enable_q;
        mem_we_d      = mem_we_q;
        mem_address_d = mem_address_q;
        mem_wr_data_d = mem_wr_data_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    mem_address_d = req_addr;
                    mem_wr_data_d = req_wdata;
                    mem_we_d      = req_we;
                    mem_enable_d  = 1'b1;
                    cnt_d         = CNT_LOAD;
                    req_ready_d   = 1'b0;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last enabled cycle: the memory has settled, so sample now.
                    rsp_rdata_d  = mem_we_q ? '0 : mem_rd_data;
                    rsp_we_d     = mem_we_q;
                    rsp_valid_d  = 1'b1;
                    mem_enable_d = 1'b0;
                    mem_we_d     = 1'b0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_we      = rsp_we_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_enable  = mem_enable_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_address_q;
    assign mem_wr_data = mem_wr_data_q;

`ifdef MEM_BUS_STATS_EN
    logic [31:0] stat_rd_q;
    logic [31:0] stat_wr_q;

    // Saturating counts of completed read and write response handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd_q <= 32'd0;
            stat_wr_q <= 32'd0;
        end else if (rsp_valid_q && rsp_ready) begin
            if (rsp_we_q) begin
                if (stat_wr_q != 32'hFFFF_FFFF) stat_wr_q <= stat_wr_q + 32'd1;
            end else begin
                if (stat_rd_q != 32'hFFFF_FFFF) stat_rd_q <= stat_rd_q + 32'd1;
            end
        end
    end

    assign stat_rd_count = stat_rd_q;
    assign stat_wr_count = stat_wr_q;
`endif

endmodule
